// File: rtl/reg_32_pkg.sv
// Shared sizing constants and word type for the 16 x 32 register file.
package reg_32_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_32_word.sv
// One storage word of the register file: async active-low clear, loads when enabled.
module reg_32_word
    import reg_32_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  word_t d,
    output word_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_32_file.sv
// 16 x 32 register file: one write port and one registered read port sharing one address.
module reg_32_file
    import reg_32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             write_data,
    output word_t             read_data
);

    word_t            words [DEPTH];
    logic [DEPTH-1:0] word_en;
    word_t            read_next;

    // An unknown address compares as unknown, so no word is enabled and nothing is corrupted.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        assign word_en[g] = write_en && (addr == ADDR_W'(g));

        reg_32_word u_word (
            .clk (clk),
            .rst (rst),
            .en  (word_en[g]),
            .d   (write_data),
            .q   (words[g])
        );
    end

    // Default to the current output so an unmatched address leaves read_data untouched.
    always_comb begin
        read_next = read_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                read_next = words[i];
            end
        end
    end

    // Samples the old word contents, giving read-before-write on a shared address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= read_next;
        end
    end

    addr_known_when_enabled : assert property (
        @(posedge clk) disable iff (!rst)
        (read_en || write_en) |-> !$isunknown(addr)
    );

endmodule

// File: tb/tb_reg_32_file.sv
// Self-checking bench for reg_32_file: directed scenarios plus random traffic against an array model.
module tb_reg_32_file;
    import reg_32_pkg::*;

    logic              clk;
    logic              rst;
    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    word_t             write_data;
    word_t             read_data;

    int    checks = 0;
    int    errors = 0;
    word_t model_mem [DEPTH];
    word_t model_rd;
    word_t sweep_val [DEPTH];

    reg_32_file dut (
        .clk        (clk),
        .rst        (rst),
        .read_en    (read_en),
        .write_en   (write_en),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on the falling edge and advances the model at the following rising edge.
    task automatic applyStimulus(input logic re, input logic we,
                                 input logic [ADDR_W-1:0] a, input word_t wd);
        @(negedge clk);
        read_en    = re;
        write_en   = we;
        addr       = a;
        write_data = wd;
        @(posedge clk);
        if (re) model_rd = model_mem[a];
        if (we) model_mem[a] = wd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input word_t expected);
        checks++;
        assert (read_data === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, read_data, expected);
        end
    endtask

    initial begin
        rst        = 1'b0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        addr       = '0;
        write_data = '0;
        model_rd   = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        #2;
        checkOutput("reset_state", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] basic write/read");
        applyStimulus(1'b0, 1'b1, 4'd0, 32'h4321_1234);
        applyStimulus(1'b0, 1'b1, 4'd1, 32'h8B9A_2468);
        applyStimulus(1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("read_addr0", 32'h4321_1234);
        applyStimulus(1'b1, 1'b0, 4'd1, 32'h0);
        checkOutput("read_addr1", 32'h8B9A_2468);

        $display("[TB] same-cycle read and write");
        applyStimulus(1'b0, 1'b1, 4'd2, 32'h1111_1111);
        applyStimulus(1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF);
        checkOutput("rbw_old", 32'h1111_1111);
        applyStimulus(1'b1, 1'b0, 4'd2, 32'h0);
        checkOutput("rbw_new", 32'hDEAD_BEEF);

        $display("[TB] read hold");
        applyStimulus(1'b0, 1'b1, 4'd3, 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b0, 4'd3, 32'h0);
        checkOutput("hold_first", 32'hCAFE_F00D);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, ADDR_W'(4 + k), $urandom);
            checkOutput("hold", 32'hCAFE_F00D);
        end

        $display("[TB] full sweep");
        for (int i = 0; i < DEPTH; i++) begin
            sweep_val[i] = word_t'(i) * 32'h4879_1234 + 32'h4321_1234;
            applyStimulus(1'b0, 1'b1, ADDR_W'(i), sweep_val[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, ADDR_W'(i), 32'h0);
            checkOutput("sweep", sweep_val[i]);
        end

        $display("[TB] no enables");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
            checkOutput("idle_hold", sweep_val[DEPTH-1]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, ADDR_W'(i), 32'h0);
            checkOutput("idle_array", sweep_val[i]);
        end

        $display("[TB] mid-cycle reset");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 32'h0000_0000);
        read_en  = 1'b0;
        write_en = 1'b0;
        model_rd = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, ADDR_W'(i), 32'h0);
            checkOutput("post_reset", 32'h0000_0000);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'($urandom), 1'($urandom),
                          ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
            checkOutput("random", model_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
